// File: rtl/sn74169_pkg.sv
// sn74169_pkg: shared constants, step-result type and Gray-step classifier
// for the sn74169 quadrature step decoder.
package sn74169_pkg;
  localparam int ERR_W = 8;
  localparam int FILT_LEN_DEF = 3;
  localparam logic [1:0] GRAY_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  typedef enum logic [1:0] {NONE, UP, DOWN, ILLEGAL} step_e;
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    gray_pos = '0;
    for (int i = 0; i < 4; i++) if (GRAY_SEQ[i] == g) gray_pos = 2'(i);
  endfunction
  // distance around the Gray ring: +1 forward, -1 reverse, 2 is a double jump
  function automatic step_e classify(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = gray_pos(cur) - gray_pos(prev);
    return d == 2'd0 ? NONE : d == 2'd1 ? UP : d == 2'd3 ? DOWN : ILLEGAL;
  endfunction
endpackage

// File: rtl/sn74169_sync_filt.sv
// sn74169_sync_filt: 1-bit 2-flop synchronizer; with QDEC_GLITCH_FILTER_EN a new
// level must persist FILT_LEN consecutive cycles before it reaches q.
module sn74169_sync_filt
`ifdef QDEC_GLITCH_FILTER_EN
#(
  parameter int FILT_LEN = sn74169_pkg::FILT_LEN_DEF
)
`endif
(
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);
  logic s1, s2;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) {s2, s1} <= 2'b00;
    else {s2, s1} <= {s1, d};
`ifdef QDEC_GLITCH_FILTER_EN
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      cnt <= '0;
      q <= 1'b0;
    end else if (s2 == q) cnt <= '0;
    else if (cnt == 4'(FILT_LEN - 1)) begin
      cnt <= '0;
      q <= s2;
    end else cnt <= cnt + 1'b1;
`else
  assign q = s2;
`endif
endmodule

// File: rtl/sn74169_qdec.sv
// sn74169_qdec: quadrature step decoder driving sn74169 U/D, ENP/ENT and LOAD pins.
// Optional input glitch filter compiled in with QDEC_GLITCH_FILTER_EN.
module sn74169_qdec
  import sn74169_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             pha,
  input  logic             phb,
  input  logic             index,
  input  logic             index_en,
  input  logic             err_clr,
  output logic             u_db,
  output logic             enpb,
  output logic             entb,
  output logic             loadb,
  output logic [ERR_W-1:0] err_cnt
);
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int WARM = 2 + FILT_LEN;
`else
  localparam int WARM = 2;
`endif
  localparam int WARM_W = $clog2(FILT_LEN + 3);
  logic [2:0] raw, syn;
  logic a, b, idx, idx_prev, first, pend, load, warm_done;
  logic [1:0] prev;
  logic [WARM_W-1:0] warm;
  step_e step;
  assign raw = {pha, phb, index};
  assign {a, b, idx} = syn;
  for (genvar i = 0; i < 3; i++) begin : g_in
    sn74169_sync_filt
`ifdef QDEC_GLITCH_FILTER_EN
      #(.FILT_LEN(FILT_LEN))
`endif
      u_sf (.clk(clk), .rstb(rstb), .d(raw[i]), .q(syn[i]));
  end
  // seeding waits until the pipeline holds a genuine post-reset sample
  always_comb begin
    warm_done = warm == WARM_W'(WARM);
    step = first ? NONE : classify(prev, {a, b});
    load = index_en & idx & ~idx_prev & ~first;
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      warm <= '0;
      first <= 1'b1;
      prev <= 2'b00;
      idx_prev <= 1'b0;
      pend <= 1'b0;
      u_db <= 1'b1;
      enpb <= 1'b1;
      loadb <= 1'b1;
      err_cnt <= '0;
    end else begin
      warm <= warm_done ? warm : warm + 1'b1;
      first <= first & ~warm_done;
      prev <= {a, b};
      idx_prev <= idx;
      pend <= step == UP || step == DOWN;
      u_db <= step == UP ? 1'b1 : step == DOWN ? 1'b0 : u_db;
      enpb <= ~(pend & ~load);
      loadb <= ~load;
      err_cnt <= err_clr ? '0 : (step == ILLEGAL && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
    end
  assign entb = enpb;
endmodule

// File: tb/tb_sn74169_qdec.sv
// tb_sn74169_qdec: table-driven, directed and randomized checks of sn74169_qdec
// against latency rules computed directly from the Gray-step definition.
module tb_sn74169_qdec;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int FL = 3;
`else
  localparam int FL = 0;
`endif
  localparam int HMIN = (FL > 1) ? FL : 1;
  localparam int RC = 600;
  typedef struct {
    logic [1:0] ph;
    logic idx;
    logic en;
    int pulses;
    int loads;
    logic udb;
    int err;
  } vec_t;
  logic clk = 0, rstb = 0, pha = 0, phb = 0, index = 0, index_en = 0, err_clr = 0;
  logic u_db, enpb, entb, loadb;
  logic [7:0] err_cnt;
  int vecs = 0, miss = 0;
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic ra [RC+1], rb [RC+1], ri [RC+1], ren [RC+1], rclr [RC+1];
  vec_t tbl [14];
  int np, nl, fp, hold, mu, merr, s;
  logic mok, found;
  logic [1:0] cur, rp;
  logic rx;

  always #5 clk = ~clk;

  sn74169_qdec #(.FILT_LEN(3)) dut (
    .clk(clk), .rstb(rstb), .pha(pha), .phb(phb), .index(index),
    .index_en(index_en), .err_clr(err_clr), .u_db(u_db), .enpb(enpb),
    .entb(entb), .loadb(loadb), .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int pos(input logic [1:0] p);
    for (int i = 0; i < 4; i++) if (seq[i] == p) return i;
    return 0;
  endfunction

  function automatic logic [1:0] fwd(input logic [1:0] p);
    return seq[(pos(p) + 1) % 4];
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] p);
    return seq[(pos(p) + 3) % 4];
  endfunction

  // Gray distance of the accepted pair used at edge k (0 none, 1 up, 3 down, 2 illegal)
  function automatic int stepcode(input int k);
    int j;
    j = k - 2 - FL;
    if (j < 2) return 0;
    return (pos({ra[j], rb[j]}) - pos({ra[j-1], rb[j-1]}) + 4) % 4;
  endfunction

  function automatic bit loadk(input int k);
    int j;
    j = k - 2 - FL;
    if (j < 2) return 0;
    return ren[k] && ri[j] && !ri[j-1];
  endfunction

  task automatic window(input int n, output int p, output int l, output int f, output logic m);
    p = 0; l = 0; f = -1; m = 1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (!enpb) begin
        p++;
        if (f < 0) f = i;
      end
      if (!loadb) l++;
      if (entb !== enpb) m = 0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b01, 1'b0, 1'b0, 1, 0, 1'b1, 0};
    tbl[1]  = '{2'b11, 1'b0, 1'b0, 1, 0, 1'b1, 0};
    tbl[2]  = '{2'b10, 1'b0, 1'b0, 1, 0, 1'b1, 0};
    tbl[3]  = '{2'b00, 1'b0, 1'b0, 1, 0, 1'b1, 0};
    tbl[4]  = '{2'b10, 1'b0, 1'b0, 1, 0, 1'b0, 0};
    tbl[5]  = '{2'b11, 1'b0, 1'b0, 1, 0, 1'b0, 0};
    tbl[6]  = '{2'b01, 1'b0, 1'b0, 1, 0, 1'b0, 0};
    tbl[7]  = '{2'b00, 1'b0, 1'b0, 1, 0, 1'b0, 0};
    tbl[8]  = '{2'b11, 1'b0, 1'b0, 0, 0, 1'b0, 1};
    tbl[9]  = '{2'b11, 1'b1, 1'b0, 0, 0, 1'b0, 1};
    tbl[10] = '{2'b11, 1'b0, 1'b1, 0, 0, 1'b0, 1};
    tbl[11] = '{2'b11, 1'b1, 1'b1, 0, 1, 1'b0, 1};
    tbl[12] = '{2'b10, 1'b1, 1'b1, 1, 0, 1'b1, 1};
    tbl[13] = '{2'b10, 1'b0, 1'b1, 0, 0, 1'b1, 1};
    repeat (3) @(negedge clk);
    chk("reset u_db", u_db, 1);
    chk("reset enpb", enpb, 1);
    chk("reset entb", entb, 1);
    chk("reset loadb", loadb, 1);
    chk("reset err_cnt", err_cnt, 0);
    rstb = 1;
    repeat (12) @(negedge clk);
    for (int r = 0; r < 14; r++) begin
      {pha, phb} = tbl[r].ph;
      index = tbl[r].idx;
      index_en = tbl[r].en;
      window(12, np, nl, fp, mok);
      chk($sformatf("t%0d pulses", r), np, tbl[r].pulses);
      chk($sformatf("t%0d loads", r), nl, tbl[r].loads);
      if (tbl[r].pulses == 1) chk($sformatf("t%0d pulse latency", r), fp, 4 + FL);
      chk($sformatf("t%0d entb mirrors enpb", r), mok, 1);
      chk($sformatf("t%0d u_db", r), u_db, tbl[r].udb);
      chk($sformatf("t%0d err_cnt", r), err_cnt, tbl[r].err);
    end
    cur = 2'b10;
    for (int i = 0; i < 300; i++) begin
      cur = ~cur;
      {pha, phb} = cur;
      repeat (HMIN) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("err saturates", err_cnt, 255);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("err clear", err_cnt, 0);
    err_clr = 1;
    cur = ~cur;
    {pha, phb} = cur;
    repeat (8 + FL) @(negedge clk);
    err_clr = 0;
    chk("clear beats illegal", err_cnt, 0);
    repeat (5) @(negedge clk);
    chk("clear beats illegal later", err_cnt, 0);
    index = 0;
    index_en = 1;
    repeat (12) @(negedge clk);
    cur = fwd(cur);
    {pha, phb} = cur;
    @(negedge clk);
    index = 1;
    window(12, np, nl, fp, mok);
    chk("collision pulses", np, 0);
    chk("collision loads", nl, 1);
    index = 0;
    repeat (12) @(negedge clk);
    index_en = 0;
    index = 1;
    window(12, np, nl, fp, mok);
    chk("index disabled loads", nl, 0);
    index = 0;
    repeat (12) @(negedge clk);
    cur = rev(cur);
    {pha, phb} = cur;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!enpb) found = 1;
    end
    chk("pulse before reset seen", found, 1);
    chk("down u_db before reset", u_db, 0);
    rstb = 0;
    #1;
    chk("async reset enpb", enpb, 1);
    chk("async reset entb", entb, 1);
    chk("async reset loadb", loadb, 1);
    chk("async reset u_db", u_db, 1);
    cur = 2'b10;
    {pha, phb} = cur;
    repeat (3) @(negedge clk);
    rstb = 1;
    window(20, np, nl, fp, mok);
    chk("reseed no pulse", np, 0);
    chk("reseed err_cnt", err_cnt, 0);
    chk("reseed u_db", u_db, 1);
`ifdef QDEC_GLITCH_FILTER_EN
    pha = ~pha;
    repeat (2) @(negedge clk);
    pha = ~pha;
    window(15, np, nl, fp, mok);
    chk("glitch rejected", np, 0);
    pha = ~pha;
    window(12, np, nl, fp, mok);
    chk("filtered step pulses", np, 1);
    chk("filtered step latency", fp, 7);
`endif
    rstb = 0;
    pha = 0; phb = 0; index = 0; index_en = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    rstb = 1;
    mu = 1; merr = 0; hold = 0; rp = 2'b00; rx = 0;
    for (int k = 1; k <= RC; k++) begin
      if (hold == 0) begin
        rp = 2'($urandom_range(0, 3));
        rx = 1'($urandom_range(0, 1));
        hold = $urandom_range(HMIN, HMIN + 4);
      end
      hold--;
      {pha, phb} = rp;
      index = rx;
      index_en = ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 39) == 0);
      ra[k] = pha; rb[k] = phb; ri[k] = index; ren[k] = index_en; rclr[k] = err_clr;
      @(negedge clk);
      s = stepcode(k);
      if (s == 1) mu = 1;
      if (s == 3) mu = 0;
      if (rclr[k]) merr = 0;
      else if (s == 2 && merr < 255) merr++;
      chk($sformatf("rnd u_db @%0d", k), u_db, mu);
      chk($sformatf("rnd enpb @%0d", k), enpb,
          !((stepcode(k - 1) == 1 || stepcode(k - 1) == 3) && !loadk(k)));
      chk($sformatf("rnd entb @%0d", k), entb,
          !((stepcode(k - 1) == 1 || stepcode(k - 1) == 3) && !loadk(k)));
      chk($sformatf("rnd loadb @%0d", k), loadb, !loadk(k));
      chk($sformatf("rnd err_cnt @%0d", k), err_cnt, merr);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
